// File: rtl/param_inv_pipe.sv
// param_inv_pipe: WIDTH-bit words flow through a DEPTH-stage registered
// pipeline with valid/ready handshaking and bubble collapsing. The word is
// XORed with INV_MASK on its move into the last stage. The block also keeps
// an occupancy count (valid stages) and a wrapping delivered-word counter.
// Optional build macro: PARAM_INV_PIPE_SVA_EN compiles in assertions and a
// cover property; without it the RTL is functionally identical.
module param_inv_pipe #(
  parameter int                 WIDTH    = 5,
  parameter int                 DEPTH    = 2,
  parameter logic [WIDTH-1:0]   INV_MASK = {WIDTH{1'b1}},
  parameter int                 CNT_W    = 8,
  localparam int                OCC_W    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic [OCC_W-1:0] occupancy,
  output logic [CNT_W-1:0] delivered
);

  logic [DEPTH-1:0] v_q, v_d;
  logic [DEPTH-1:0] adv;
  logic [WIDTH-1:0] d_q [DEPTH];
  logic [WIDTH-1:0] d_d [DEPTH];
  logic [OCC_W-1:0] occ_q, occ_d;
  logic [CNT_W-1:0] dlv_q, dlv_d;
  logic             accept;

  // Ready chain: a stage advances when the stage ahead is empty or itself
  // advancing, so bubbles ahead of a stalled word are always filled.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // through the block leaves it unassigned and infers a latch.
    adv            = '0;
    adv[DEPTH-1]   = v_q[DEPTH-1] & out_ready;
    for (int k = DEPTH - 2; k >= 0; k--) begin
      adv[k] = v_q[k] & (~v_q[k+1] | adv[k+1]);
    end
  end

  assign in_ready  = ~v_q[0] | adv[0];
  assign accept    = in_valid & in_ready;
  assign out_valid = v_q[DEPTH-1];
  assign out_data  = d_q[DEPTH-1];
  assign occupancy = occ_q;
  assign delivered = dlv_q;

  // Next-state: load, move or clear each stage; data of a stage that
  // empties is left as-is, only its valid bit drops.
  always_comb begin
    v_d = v_q;
    d_d = d_q;
    v_d[0] = accept | (v_q[0] & ~adv[0]);
    if (accept) d_d[0] = in_data;
    for (int k = 1; k < DEPTH; k++) begin
      v_d[k] = adv[k-1] | (v_q[k] & ~adv[k]);
      if (adv[k-1]) begin
        d_d[k] = (k == DEPTH - 1) ? (d_q[k-1] ^ INV_MASK) : d_q[k-1];
      end
    end
    occ_d = '0;
    for (int k = 0; k < DEPTH; k++) begin
      occ_d = occ_d + OCC_W'(v_d[k]);
    end
    dlv_d = dlv_q + CNT_W'(out_valid & out_ready);
  end

  // Stage, occupancy and delivered-counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q   <= '0;
      occ_q <= '0;
      dlv_q <= '0;
      // NOTE: the stage data array is reset too, because out_data must read
      // zero during reset; it is only DEPTH words, so this is cheap.
      for (int k = 0; k < DEPTH; k++) d_q[k] <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of statement order.
      v_q   <= v_d;
      d_q   <= d_d;
      occ_q <= occ_d;
      dlv_q <= dlv_d;
    end
  end

`ifdef PARAM_INV_PIPE_SVA_EN
  logic [WIDTH-1:0] first_q;
  logic             first_seen_q;

  // Remember the first word accepted after reset as the cover target.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      first_q      <= '0;
      first_seen_q <= 1'b0;
    end else if (accept && !first_seen_q) begin
      first_q      <= in_data;
      first_seen_q <= 1'b1;
    end
  end

  a_occ_max: assert property (@(posedge clk) disable iff (!rst_n)
    occupancy <= OCC_W'(DEPTH));

  a_out_stable: assert property (@(posedge clk) disable iff (!rst_n)
    (out_valid && !out_ready) |=> $stable(out_data));

  a_full_when_blocked: assert property (@(posedge clk) disable iff (!rst_n)
    !in_ready |-> &v_q);

  c_fill_and_deliver: cover property (@(posedge clk) disable iff (!rst_n)
    (occupancy == '0) ##(DEPTH + 8)
    (out_valid && out_ready && first_seen_q &&
     out_data == (first_q ^ INV_MASK) && occupancy == OCC_W'(DEPTH)));
`else
  // Default build: no properties compiled in.
`endif

endmodule

// File: tb/tb_param_inv_pipe.sv
// Testbench for param_inv_pipe: a scoreboard on the default instance plus
// directed checks on a CNT_W=2 instance and a DEPTH=4 / INV_MASK=00011 one.
module tb_param_inv_pipe;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Default instance (WIDTH=5, DEPTH=2, INV_MASK=1F, CNT_W=8)
  logic       in_valid, in_ready, out_valid, out_ready;
  logic [4:0] in_data, out_data;
  logic [1:0] occupancy;
  logic [7:0] delivered;

  param_inv_pipe dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .occupancy(occupancy), .delivered(delivered)
  );

  // CNT_W=2 instance
  logic       in_valid_c, in_ready_c, out_valid_c, out_ready_c;
  logic [4:0] in_data_c, out_data_c;
  logic [1:0] occupancy_c;
  logic [1:0] delivered_c;

  param_inv_pipe #(.CNT_W(2)) dut_c (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid_c), .in_data(in_data_c), .in_ready(in_ready_c),
    .out_valid(out_valid_c), .out_data(out_data_c), .out_ready(out_ready_c),
    .occupancy(occupancy_c), .delivered(delivered_c)
  );

  // DEPTH=4, INV_MASK=00011 instance
  logic       in_valid_d, in_ready_d, out_valid_d, out_ready_d;
  logic [4:0] in_data_d, out_data_d;
  logic [2:0] occupancy_d;
  logic [7:0] delivered_d;

  param_inv_pipe #(.DEPTH(4), .INV_MASK(5'b00011)) dut_d (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid_d), .in_data(in_data_d), .in_ready(in_ready_d),
    .out_valid(out_valid_d), .out_data(out_data_d), .out_ready(out_ready_d),
    .occupancy(occupancy_d), .delivered(delivered_d)
  );

  int         checks = 0;
  int         errors = 0;
  logic [4:0] exp_q [$];
  logic [7:0] exp_deliv = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor for the default instance: pop and compare on each handshake,
  // and track the delivered counter.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_deliv = '0;
      end else begin
        check("delivered", {24'd0, delivered}, {24'd0, exp_deliv});
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_out: got %0h expected no word", out_data);
          end else begin
            check("out_data", {27'd0, out_data}, {27'd0, exp_q.pop_front()});
          end
          exp_deliv++;
        end
      end
    end
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  logic [1:0] exp_dc [5];

  initial begin
    exp_dc[0] = 2'd1; exp_dc[1] = 2'd2; exp_dc[2] = 2'd3;
    exp_dc[3] = 2'd0; exp_dc[4] = 2'd1;

    // ---- Reset with a word offered ----
    rst_n = 1'b0;
    in_valid = 1'b1; in_data = 5'h1F; out_ready = 1'b1;
    in_valid_c = 1'b0; in_data_c = '0; out_ready_c = 1'b1;
    in_valid_d = 1'b0; in_data_d = '0; out_ready_d = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_data", {27'd0, out_data}, 32'd0);
    check("rst_occupancy", {30'd0, occupancy}, 32'd0);
    check("rst_delivered", {24'd0, delivered}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    check("post_rst_out_valid", {31'd0, out_valid}, 32'd0);

    // ---- Single word, latency DEPTH-1 edges after acceptance ----
    in_valid = 1'b1; in_data = 5'b10101;
    #1;
    check("single_in_ready", {31'd0, in_ready}, 32'd1);
    exp_q.push_back(5'b01010);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("single_lat_v0", {31'd0, out_valid}, 32'd0);
    check("single_occ", {30'd0, occupancy}, 32'd1);
    @(posedge clk);
    #1;
    check("single_lat_v1", {31'd0, out_valid}, 32'd1);
    check("single_data", {27'd0, out_data}, {27'd0, 5'b01010});
    @(posedge clk);
    #1;
    check("single_delivered", {24'd0, delivered}, 32'd1);
    check("single_occ_empty", {30'd0, occupancy}, 32'd0);

    // ---- Stream 0..9 back to back ----
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; in_data = 5'(i);
      #1;
      check("stream_in_ready", {31'd0, in_ready}, 32'd1);
      exp_q.push_back(5'(i) ^ 5'h1F);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("stream_drained", exp_q.size(), 32'd0);
    check("stream_delivered", {24'd0, delivered}, 32'd11);

    // ---- Stall: fill, hold, then release with simultaneous accept ----
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 5'b00011;
    #1;
    check("stall_rdy0", {31'd0, in_ready}, 32'd1);
    exp_q.push_back(5'b11100);
    @(posedge clk);
    #1;
    in_data = 5'b00101;
    #1;
    check("stall_rdy1", {31'd0, in_ready}, 32'd1);
    exp_q.push_back(5'b11010);
    @(posedge clk);
    #1;
    in_data = 5'b01001;
    #1;
    check("stall_occ_full", {30'd0, occupancy}, 32'd2);
    check("stall_in_ready_low", {31'd0, in_ready}, 32'd0);
    check("stall_out_data", {27'd0, out_data}, {27'd0, 5'b11100});
    repeat (2) @(posedge clk);
    #1;
    check("stall_hold_data", {27'd0, out_data}, {27'd0, 5'b11100});
    check("stall_hold_occ", {30'd0, occupancy}, 32'd2);
    out_ready = 1'b1;
    #1;
    check("release_in_ready", {31'd0, in_ready}, 32'd1);
    exp_q.push_back(5'b10110);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("release_occ_same", {30'd0, occupancy}, 32'd2);
    repeat (3) @(posedge clk);
    #1;
    check("release_drained", exp_q.size(), 32'd0);
    check("release_occ_empty", {30'd0, occupancy}, 32'd0);
    check("release_delivered", {24'd0, delivered}, 32'd14);

    // ---- Reset mid-stream with two words in flight ----
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 5'b00111;
    exp_q.push_back(5'b11000);
    @(posedge clk);
    #1;
    in_data = 5'b01111;
    exp_q.push_back(5'b10000);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("mid_occ_before", {30'd0, occupancy}, 32'd2);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_occ", {30'd0, occupancy}, 32'd0);
    check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
    exp_q.delete();
    @(posedge clk);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("mid_no_stale", {31'd0, out_valid}, 32'd0);
    check("mid_delivered", {24'd0, delivered}, 32'd0);

    // ---- CNT_W=2: delivered wraps 1,2,3,0,1 ----
    for (int i = 0; i < 5; i++) begin
      in_valid_c = 1'b1; in_data_c = 5'(i + 3);
      @(posedge clk);
      #1;
      in_valid_c = 1'b0;
      @(posedge clk);
      #1;
      check("cnt2_data", {27'd0, out_data_c}, {27'd0, 5'(i + 3) ^ 5'h1F});
      @(posedge clk);
      #1;
      check("cnt2_delivered", {30'd0, delivered_c}, {30'd0, exp_dc[i]});
    end

    // ---- DEPTH=4, INV_MASK=00011: latency, bubble collapse, fill, drain ----
    in_valid_d = 1'b1; in_data_d = 5'b10000;
    #1;
    check("d4_in_ready", {31'd0, in_ready_d}, 32'd1);
    @(posedge clk);
    #1;
    in_valid_d = 1'b0;
    check("d4_occ1", {29'd0, occupancy_d}, 32'd1);
    check("d4_lat_e1", {31'd0, out_valid_d}, 32'd0);
    @(posedge clk);
    #1;
    check("d4_lat_e2", {31'd0, out_valid_d}, 32'd0);
    @(posedge clk);
    #1;
    check("d4_lat_e3", {31'd0, out_valid_d}, 32'd0);
    @(posedge clk);
    #1;
    check("d4_lat_e4", {31'd0, out_valid_d}, 32'd1);
    check("d4_data", {27'd0, out_data_d}, {27'd0, 5'b10011});
    in_valid_d = 1'b1; in_data_d = 5'b00001;
    @(posedge clk);
    #1;
    in_data_d = 5'b00010;
    @(posedge clk);
    #1;
    in_data_d = 5'b00100;
    @(posedge clk);
    #1;
    in_valid_d = 1'b0;
    check("d4_occ_full", {29'd0, occupancy_d}, 32'd4);
    check("d4_in_ready_low", {31'd0, in_ready_d}, 32'd0);
    check("d4_hold_data", {27'd0, out_data_d}, {27'd0, 5'b10011});
    out_ready_d = 1'b1;
    @(posedge clk);
    #1;
    check("d4_drain1", {27'd0, out_data_d}, {27'd0, 5'b00010});
    check("d4_drain1_occ", {29'd0, occupancy_d}, 32'd3);
    @(posedge clk);
    #1;
    check("d4_drain2", {27'd0, out_data_d}, {27'd0, 5'b00001});
    @(posedge clk);
    #1;
    check("d4_drain3", {27'd0, out_data_d}, {27'd0, 5'b00111});
    @(posedge clk);
    #1;
    check("d4_empty", {31'd0, out_valid_d}, 32'd0);
    check("d4_occ_empty", {29'd0, occupancy_d}, 32'd0);
    check("d4_delivered", {24'd0, delivered_d}, 32'd4);

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
